// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_sampler
// Purpose  : Periodic SPI mode-0 ADC reader, MSB first, feeding the averager.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_sampler #(
  parameter int N             = 16,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         spi_miso,
  output logic         spi_sclk,
  output logic         spi_cs_n,
  output logic [N-1:0] data_out,
  output logic         fit_data,
  output logic         busy,
  output logic         overrun
);

  localparam int c_TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [c_TW-1:0] c_TMAX    = c_TW'(SAMPLE_PERIOD - 1);
  localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(CLK_DIV - 1);
  localparam logic [c_BW-1:0] c_BIT_MAX = c_BW'(N - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_TW-1:0] timer_q, timer_d;
  logic [c_DW-1:0] div_q,   div_d;
  logic [c_BW-1:0] bit_q,   bit_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    data_q,  data_d;
  logic            sclk_q,  sclk_d;
  logic            cs_n_q,  cs_n_d;
  logic            fit_q,   fit_d;
  logic            ovr_q,   ovr_d;

  logic w_trigger;
  logic w_div_end;
  logic w_last_bit;
  logic w_frame_end;

  assign w_trigger   = enable && (timer_q == c_TMAX);
  assign w_div_end   = (div_q == c_DIV_MAX);
  assign w_last_bit  = (bit_q == c_BIT_MAX);
  // Frame ends when the low phase after the final pulse runs out.
  assign w_frame_end = (state_q == c_SHIFT) && w_div_end && !sclk_q && w_last_bit;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      timer_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      fit_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      fit_q   <= fit_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_trigger) state_d = c_SETUP;
      c_SETUP: if (w_div_end) state_d = c_SHIFT;
      c_SHIFT: if (w_frame_end) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Sample timer: free-runs while enabled, parked at zero otherwise
  always_comb begin
    timer_d = '0;
    if (enable && (timer_q != c_TMAX)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Output and datapath logic
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    fit_d   = 1'b0;
    ovr_d   = ovr_q;

    if (w_trigger && (state_q != c_IDLE)) begin
      ovr_d = 1'b1;
    end
    if (!enable) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      c_IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = !w_trigger;
        div_d  = '0;
        bit_d  = '0;
      end
      c_SETUP: begin
        if (w_div_end) begin
          // Leaving setup is the first rising SCLK edge: capture bit N-1.
          div_d   = '0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[N-2:0], spi_miso};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      c_SHIFT: begin
        if (w_div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (w_last_bit) begin
            cs_n_d = 1'b1;
            data_d = shift_q;
            fit_d  = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[N-2:0], spi_miso};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        div_d  = '0;
        bit_d  = '0;
      end
    endcase
  end

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign data_out = data_q;
  assign fit_data = fit_q;
  assign busy     = (state_q != c_IDLE);
  assign overrun  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_sampler
// Purpose  : Self-checking bench for adc_spi_sampler (periods 100 and 40).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_sampler;

  localparam int N     = 16;
  localparam int CD    = 2;
  localparam int SP0   = 100;
  localparam int SP1   = 40;
  localparam int FRAME = CD * (2 * N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0, rst1, en0, en1;
  logic rst_a [2];
  logic en_a  [2];
  assign rst_a[0] = rst0;
  assign rst_a[1] = rst1;
  assign en_a[0]  = en0;
  assign en_a[1]  = en1;

  logic         miso_r [2];
  logic         sclk_w [2];
  logic         cs_w   [2];
  logic         fit_w  [2];
  logic         busy_w [2];
  logic         ovr_w  [2];
  logic [N-1:0] data_w [2];

  adc_spi_sampler #(.N(N), .CLK_DIV(CD), .SAMPLE_PERIOD(SP0)) u_dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .spi_miso(miso_r[0]),
    .spi_sclk(sclk_w[0]), .spi_cs_n(cs_w[0]), .data_out(data_w[0]),
    .fit_data(fit_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
  );

  adc_spi_sampler #(.N(N), .CLK_DIV(CD), .SAMPLE_PERIOD(SP1)) u_dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .spi_miso(miso_r[1]),
    .spi_sclk(sclk_w[1]), .spi_cs_n(cs_w[1]), .data_out(data_w[1]),
    .fit_data(fit_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  logic done1 = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h expected %h at t=%0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int sp_of(input int d);
    return (d == 0) ? SP0 : SP1;
  endfunction

  // Word the ADC returns in its k-th frame
  function automatic logic [N-1:0] words(input int d, input int k);
    logic [N-1:0] w;
    w = 16'h0BAD ^ N'(k);
    if (d == 0) begin
      case (k)
        0: w = 16'hA5C3;
        1: w = 16'h0001;
        2: w = 16'hFFFF;
        3: w = 16'h8000;
        4: w = 16'h7FFF;
        5: w = 16'h1234;
        6: w = 16'h5A5A;
        7: w = 16'hC0DE;
        default: ;
      endcase
    end else begin
      case (k)
        0: w = 16'h3C3C;
        1: w = 16'h9999;
        2: w = 16'h0F0F;
        default: ;
      endcase
    end
    return w;
  endfunction

  // ADC model: MSB out when CS falls, next bit after each SCLK fall.
  initial begin
    int           a_idx    [2];
    int           a_starts [2];
    logic [N-1:0] a_word   [2];
    logic         a_pcs    [2];
    logic         a_psclk  [2];
    for (int d = 0; d < 2; d++) begin
      a_idx[d] = 0; a_starts[d] = 0; a_word[d] = '0;
      a_pcs[d] = 1'b1; a_psclk[d] = 1'b0; miso_r[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cs_w[d] !== 1'b0) begin
          a_idx[d] = 0;
        end else if (a_pcs[d]) begin
          a_word[d] = words(d, a_starts[d]);
          a_starts[d]++;
          a_idx[d] = 0;
        end else if (a_psclk[d] === 1'b1 && sclk_w[d] === 1'b0) begin
          a_idx[d]++;
        end
        miso_r[d] = (a_idx[d] < N) ? a_word[d][N-1-a_idx[d]] : 1'b0;
        a_pcs[d]   = (cs_w[d] !== 1'b0);
        a_psclk[d] = sclk_w[d];
      end
    end
  end

  // Reference model: frame position counted from the trigger edge
  int           m_timer  [2];
  int           m_f      [2];
  int           m_starts [2];
  logic [N-1:0] m_data   [2];
  logic [N-1:0] m_word   [2];
  logic         m_fit    [2];
  logic         m_ovr    [2];
  logic         m_valid  [2];

  initial begin
    bit was_busy, trig;
    for (int d = 0; d < 2; d++) begin
      m_timer[d] = 0; m_f[d] = -1; m_starts[d] = 0; m_data[d] = '0;
      m_word[d] = '0; m_fit[d] = 1'b0; m_ovr[d] = 1'b0; m_valid[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_a[d] === 1'b1) begin
          m_timer[d] = 0; m_f[d] = -1; m_data[d] = '0;
          m_fit[d] = 1'b0; m_ovr[d] = 1'b0; m_valid[d] = 1'b1;
        end else if (m_valid[d]) begin
          was_busy   = (m_f[d] >= 0);
          trig       = en_a[d] && (m_timer[d] == sp_of(d) - 1);
          m_timer[d] = en_a[d] ? (m_timer[d] + 1) % sp_of(d) : 0;
          m_fit[d]   = 1'b0;
          if (was_busy) begin
            m_f[d]++;
            if (m_f[d] == FRAME) begin
              m_f[d] = -1; m_data[d] = m_word[d]; m_fit[d] = 1'b1;
            end
          end
          if (trig) begin
            if (was_busy) m_ovr[d] = 1'b1;
            else begin
              m_f[d] = 0; m_word[d] = words(d, m_starts[d]); m_starts[d]++;
            end
          end
          if (!en_a[d]) m_ovr[d] = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    logic exp_sclk;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d]) begin
          exp_sclk = (m_f[d] >= CD) && ((((m_f[d] - CD) / CD) % 2) == 0);
          check("cs_n", d, cs_w[d], (m_f[d] < 0));
          check("sclk", d, sclk_w[d], exp_sclk);
          check("busy", d, busy_w[d], (m_f[d] >= 0));
          check("fit_data", d, fit_w[d], m_fit[d]);
          check("data_out", d, data_w[d], m_data[d]);
          check("overrun", d, ovr_w[d], m_ovr[d]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fit(input int d, input int max_cyc, output int low, output int rises);
    logic prev;
    logic ok;
    low = 0; rises = 0; prev = 1'b0; ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (cs_w[d] === 1'b0) low++;
      if (sclk_w[d] === 1'b1 && !prev) rises++;
      prev = sclk_w[d];
      if (fit_w[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("fit_timeout", d, ok, 1'b1);
  endtask

  task automatic wait_cs_low(input int d, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (cs_w[d] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("cs_low_timeout", d, ok, 1'b1);
  endtask

  task automatic check_idle_reset(input int d);
    check("rst_cs_n", d, cs_w[d], 1'b1);
    check("rst_sclk", d, sclk_w[d], 1'b0);
    check("rst_data", d, data_w[d], 16'h0000);
    check("rst_fit", d, fit_w[d], 1'b0);
    check("rst_busy", d, busy_w[d], 1'b0);
    check("rst_overrun", d, ovr_w[d], 1'b0);
  endtask

  // Period-40 instance: frames on triggers 1, 3, 5
  initial begin
    int low, rises, t_prev;
    logic [N-1:0] exp1 [3];
    exp1[0] = 16'h3C3C; exp1[1] = 16'h9999; exp1[2] = 16'h0F0F;
    rst1 = 1'b1; en1 = 1'b1;
    repeat (3) tick();
    check_idle_reset(1);
    rst1 = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_fit(1, 200, low, rises);
      check("p40_low_cycles", 1, low, 66);
      check("p40_sclk_pulses", 1, rises, 16);
      check("p40_data", 1, data_w[1], exp1[k]);
      check("p40_overrun", 1, ovr_w[1], 1'b1);
      if (k > 0) check("p40_spacing", 1, cyc - t_prev, 80);
      t_prev = cyc;
    end
    en1 = 1'b0;
    tick(); tick();
    check("p40_overrun_cleared", 1, ovr_w[1], 1'b0);
    done1 = 1'b1;
  end

  // Period-100 instance: main directed sequence
  initial begin
    int low, rises, t_prev, lowc;
    logic [N-1:0] exp3 [4];
    exp3[0] = 16'h0001; exp3[1] = 16'hFFFF; exp3[2] = 16'h8000; exp3[3] = 16'h7FFF;
    rst0 = 1'b1; en0 = 1'b1;
    repeat (3) tick();
    check_idle_reset(0);
    rst0 = 1'b0;

    wait_fit(0, 300, low, rises);
    check("single_low_cycles", 0, low, 66);
    check("single_sclk_pulses", 0, rises, 16);
    check("single_data", 0, data_w[0], 16'hA5C3);
    check("single_busy_at_fit", 0, busy_w[0], 1'b0);
    check("single_cs_at_fit", 0, cs_w[0], 1'b1);
    t_prev = cyc;

    for (int k = 0; k < 4; k++) begin
      wait_fit(0, 200, low, rises);
      check("multi_data", 0, data_w[0], exp3[k]);
      check("multi_spacing", 0, cyc - t_prev, 100);
      check("multi_low_cycles", 0, low, 66);
      t_prev = cyc;
    end
    check("multi_overrun", 0, ovr_w[0], 1'b0);

    // Drop enable at bit 8 of the next frame
    wait_cs_low(0, 200);
    repeat (CD + 8 * 2 * CD) tick();
    en0 = 1'b0;
    wait_fit(0, 200, low, rises);
    check("en_drop_data", 0, data_w[0], 16'h1234);
    check("en_drop_overrun", 0, ovr_w[0], 1'b0);
    lowc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cs_w[0] !== 1'b1) lowc++;
    end
    check("en_drop_quiet", 0, lowc, 0);

    // Reset at bit 8 of a frame
    en0 = 1'b1;
    wait_cs_low(0, 200);
    repeat (CD + 8 * 2 * CD) tick();
    rst0 = 1'b1; en0 = 1'b0;
    tick();
    check_idle_reset(0);
    rst0 = 1'b0; en0 = 1'b1;
    wait_fit(0, 300, low, rises);
    check("post_rst_low_cycles", 0, low, 66);
    check("post_rst_sclk_pulses", 0, rises, 16);
    check("post_rst_data", 0, data_w[0], 16'hC0DE);

    for (int i = 0; i < 2000 && !done1; i++) tick();
    check("p40_sequence_done", 1, done1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
